// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : switch_conditioner
// Purpose  : Conditions raw slide-switch pins for the control path. Each bit
//            passes through a SYNC_STAGES-deep synchroniser, a debounce
//            counter and a registered rise/fall pulse generator.
// Option   : define SWITCH_STEP_PULSE_EN to turn stepEn into a one-cycle
//            single-step pulse taken from switch STEP_BIT. Without it stepEn
//            is tied high and the CPU runs freely.
// Revision : 1.0 - initial release
// ============================================================================
module switch_conditioner #(
  parameter int W               = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP_BIT        = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] switchesRaw,
  output logic [W-1:0] switchesOut,
  output logic [W-1:0] risePulse,
  output logic [W-1:0] fallPulse,
  output logic         stepEn
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal configurations at elaboration time.
  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("switch_conditioner: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("switch_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (STEP_BIT < 0 || STEP_BIT >= W) begin : g_bad_step
      $error("switch_conditioner: STEP_BIT must index a switch bit");
    end
  endgenerate

  // Next-cycle rise indication per bit; the step register shares it so that
  // stepEn lines up exactly with risePulse[STEP_BIT].
  logic [W-1:0] rise_next;

  generate
    for (genvar i = 0; i < W; i++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_lvl;
      logic [CNT_W-1:0]       cnt_q;
      logic                   out_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   mismatch;
      logic                   accept;

      assign sync_lvl     = sync_q[SYNC_STAGES-1];
      assign mismatch     = (sync_lvl != out_q);
      assign accept       = mismatch && (cnt_q == CNT_MAX);
      assign rise_next[i] = accept && sync_lvl;

      // Plain shift chain; bit 0 is the metastability-exposed capture flop.
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], switchesRaw[i]};
        end
      end

      // Debounce: count consecutive disagreeing cycles, accept on the last one.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q  <= '0;
          out_q  <= 1'b0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          if (!mismatch) begin
            cnt_q <= '0;
          end else if (accept) begin
            out_q  <= sync_lvl;
            cnt_q  <= '0;
            rise_q <= sync_lvl;
            fall_q <= ~sync_lvl;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end

      assign switchesOut[i] = out_q;
      assign risePulse[i]   = rise_q;
      assign fallPulse[i]   = fall_q;
    end
  endgenerate

`ifdef SWITCH_STEP_PULSE_EN
  logic step_q;

  // One program-counter advance per debounced press of the step switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= rise_next[STEP_BIT];
    end
  end

  assign stepEn = step_q;
`else
  logic unused_rise;
  assign unused_rise = ^rise_next;

  // Free-running CPU: the program counter advances every cycle.
  assign stepEn = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_conditioner
// Purpose  : Directed self-checking bench for switch_conditioner with
//            SYNC_STAGES=2, DEBOUNCE_CYCLES=4, W=10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] switchesRaw = '0;
  logic [9:0] switchesOut;
  logic [9:0] risePulse;
  logic [9:0] fallPulse;
  logic       stepEn;

  int checks   = 0;
  int failures = 0;

  switch_conditioner #(
    .W              (10),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .STEP_BIT       (9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .switchesRaw(switchesRaw),
    .switchesOut(switchesOut),
    .risePulse  (risePulse),
    .fallPulse  (fallPulse),
    .stepEn     (stepEn)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges; returns just after the last reset edge with rst low.
  task automatic do_reset();
    rst         = 1'b1;
    switchesRaw = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_step;
`ifdef SWITCH_STEP_PULSE_EN
    exp_step = 1'b0;
`else
    exp_step = 1'b1;
`endif
    do_reset();
    checks++;
    if (switchesOut !== 10'h000 || risePulse !== 10'h000 || fallPulse !== 10'h000) begin
      failures++;
      $display("FAIL reset_outputs out=%h rise=%h fall=%h required all 000", switchesOut, risePulse, fallPulse);
    end
    checks++;
    if (stepEn !== exp_step) begin
      failures++;
      $display("FAIL reset_step got=%b required=%b", stepEn, exp_step);
    end
  endtask

  task automatic test_clean_rise();
    logic [9:0] exp_out, exp_rise;
    do_reset();
    switchesRaw = 10'h001;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_out  = (t >= 6) ? 10'h001 : 10'h000;
      exp_rise = (t == 6) ? 10'h001 : 10'h000;
      checks++;
      if (switchesOut !== exp_out || risePulse !== exp_rise || fallPulse !== 10'h000) begin
        failures++;
        $display("FAIL clean_rise t=%0d out=%h rise=%h fall=%h required out=%h rise=%h fall=000",
                 t, switchesOut, risePulse, fallPulse, exp_out, exp_rise);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    switchesRaw = 10'h008;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 3) switchesRaw = 10'h000;
      checks++;
      if (switchesOut !== 10'h000 || risePulse !== 10'h000 || fallPulse !== 10'h000) begin
        failures++;
        $display("FAIL glitch t=%0d out=%h rise=%h fall=%h required all 000",
                 t, switchesOut, risePulse, fallPulse);
      end
    end
  endtask

  task automatic test_fall_concurrent();
    logic [9:0] exp_out, exp_fall;
    do_reset();
    switchesRaw = 10'h3FF;
    for (int t = 1; t <= 8; t++) tick();
    checks++;
    if (switchesOut !== 10'h3FF) begin
      failures++;
      $display("FAIL fall_preload out=%h required=3ff", switchesOut);
    end
    switchesRaw = 10'h0F0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_out  = (t >= 6) ? 10'h0F0 : 10'h3FF;
      exp_fall = (t == 6) ? 10'h30F : 10'h000;
      checks++;
      if (switchesOut !== exp_out || fallPulse !== exp_fall || risePulse !== 10'h000) begin
        failures++;
        $display("FAIL fall_concurrent t=%0d out=%h rise=%h fall=%h required out=%h rise=000 fall=%h",
                 t, switchesOut, risePulse, fallPulse, exp_out, exp_fall);
      end
    end
  endtask

  task automatic test_bounce();
    logic [9:0] exp_out, exp_rise;
    do_reset();
    switchesRaw = 10'h001;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp_out  = (t >= 10) ? 10'h001 : 10'h000;
      exp_rise = (t == 10) ? 10'h001 : 10'h000;
      checks++;
      if (switchesOut !== exp_out || risePulse !== exp_rise || fallPulse !== 10'h000) begin
        failures++;
        $display("FAIL bounce t=%0d out=%h rise=%h fall=%h required out=%h rise=%h fall=000",
                 t, switchesOut, risePulse, fallPulse, exp_out, exp_rise);
      end
      if (t == 2) switchesRaw = 10'h000;
      if (t == 4) switchesRaw = 10'h001;
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [9:0] exp_out, exp_rise;
    do_reset();
    switchesRaw = 10'h001;
    for (int t = 1; t <= 8; t++) tick();
    switchesRaw = 10'h021;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (switchesOut !== 10'h000 || risePulse !== 10'h000 || fallPulse !== 10'h000) begin
      failures++;
      $display("FAIL mid_reset_clear out=%h rise=%h fall=%h required all 000",
               switchesOut, risePulse, fallPulse);
    end
    for (int t = 5; t <= 12; t++) begin
      tick();
      exp_out  = (t >= 10) ? 10'h021 : 10'h000;
      exp_rise = (t == 10) ? 10'h021 : 10'h000;
      checks++;
      if (switchesOut !== exp_out || risePulse !== exp_rise || fallPulse !== 10'h000) begin
        failures++;
        $display("FAIL mid_reset t=%0d out=%h rise=%h fall=%h required out=%h rise=%h fall=000",
                 t, switchesOut, risePulse, fallPulse, exp_out, exp_rise);
      end
    end
  endtask

  task automatic test_step();
    logic exp_step;
    int   highs;
    highs = 0;
    do_reset();
    switchesRaw = 10'h200;
    for (int t = 1; t <= 40; t++) begin
      tick();
`ifdef SWITCH_STEP_PULSE_EN
      exp_step = (t == 6 || t == 26);
`else
      exp_step = 1'b1;
`endif
      if (stepEn === 1'b1) highs++;
      checks++;
      if (stepEn !== exp_step) begin
        failures++;
        $display("FAIL step t=%0d got=%b required=%b", t, stepEn, exp_step);
      end
      if (t == 10) switchesRaw = 10'h000;
      if (t == 20) switchesRaw = 10'h200;
      if (t == 30) switchesRaw = 10'h000;
    end
`ifdef SWITCH_STEP_PULSE_EN
    checks++;
    if (highs != 2) begin
      failures++;
      $display("FAIL step_count got=%0d required=2", highs);
    end
`else
    checks++;
    if (highs != 40) begin
      failures++;
      $display("FAIL step_count got=%0d required=40", highs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_fall_concurrent();
    test_bounce();
    test_reset_mid_debounce();
    test_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
